bus_bridge_slave_ctrl: RTL and testbench

//  Remote-side bus bridge controller. It sits behind a bus slave port, accepts one parallel request at a time
//  (mode/addr/wdata) and packs it into a 32-bit UART TX frame {7'b0, mode, data[7:0], 2'b0, addr[13:0]}.
//  The bus_bridge_master on the far board decodes this frame. For reads it then waits for the 16-bit UART
//  RX reply {8'b0, rdata} and returns rdata. A timeout guards against a lost reply.

---
 rtl/bus_bridge_slave_ctrl.sv | 122 ++++++++++++
 tb/tb_bus_bridge_slave_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_bridge_slave_ctrl.sv
// rtl/bus_bridge_slave_ctrl.sv - remote-side bus bridge controller
// Packs one bus request into a UART TX frame and, for reads, waits for the UART RX reply.
module bus_bridge_slave_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int BB_ADDR_WIDTH  = 14,
  parameter int TX_FRAME_WIDTH = 32,
  parameter int RX_FRAME_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_mode,
  input  logic [BB_ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_timeout,
  output logic [TX_FRAME_WIDTH-1:0] u_din,
  output logic                      u_en,
  input  logic                      u_tx_busy,
  input  logic                      u_rx_ready,
  input  logic [RX_FRAME_WIDTH-1:0] u_dout
);

  localparam int TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DATA_LSB = BB_ADDR_WIDTH + 2;
  localparam int MODE_BIT = DATA_LSB + DATA_WIDTH;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SEND, TX_START, TX_DONE, WAIT_RX, RESP} state_t;

  state_t                      state_q, state_d;
  logic [TX_FRAME_WIDTH-1:0]   u_din_q, u_din_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic [DATA_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                        rsp_timeout_q, rsp_timeout_d;
  logic                        prev_rx_ready_q, prev_rx_ready_d;
  logic                        rx_edge;
  logic                        unused_rx_upper;

  // The reply's upper byte carries nothing for this bridge.
  assign unused_rx_upper = ^u_dout[RX_FRAME_WIDTH-1:DATA_WIDTH];
  assign rx_edge         = u_rx_ready & ~prev_rx_ready_q;

  always_comb begin
    state_d         = state_q;
    u_din_d         = u_din_q;
    timer_d         = timer_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_timeout_d   = rsp_timeout_q;
    prev_rx_ready_d = u_rx_ready;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          u_din_d                        = '0;
          u_din_d[BB_ADDR_WIDTH-1:0]     = req_addr;
          if (req_mode) u_din_d[DATA_LSB +: DATA_WIDTH] = req_wdata;
          u_din_d[MODE_BIT]              = req_mode;
          state_d                        = SEND;
        end
      end
      SEND:     state_d = TX_START;
      TX_START: if (u_tx_busy) state_d = TX_DONE;
      TX_DONE: begin
        if (!u_tx_busy) begin
          if (u_din_q[MODE_BIT]) begin
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b0;
            state_d       = RESP;
          end else begin
            timer_d = '0;
            state_d = WAIT_RX;
          end
        end
      end
      WAIT_RX: begin
        // A reply arriving on the final timer cycle still counts as delivered.
        if (rx_edge) begin
          rsp_rdata_d   = u_dout[DATA_WIDTH-1:0];
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      u_din_q         <= '0;
      timer_q         <= '0;
      rsp_rdata_q     <= '0;
      rsp_timeout_q   <= 1'b0;
      prev_rx_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      u_din_q         <= u_din_d;
      timer_q         <= timer_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_timeout_q   <= rsp_timeout_d;
      prev_rx_ready_q <= prev_rx_ready_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign u_en        = (state_q == SEND);
  assign rsp_valid   = (state_q == RESP);
  assign u_din       = u_din_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_bus_bridge_slave_ctrl.sv
// tb/tb_bus_bridge_slave_ctrl.sv - self-checking bench for bus_bridge_slave_ctrl
// Transaction-level latency/value model plus directed and randomized requests.
module tb_bus_bridge_slave_ctrl;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_mode = 1'b0;
  logic [13:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic [31:0] u_din;
  logic        u_en;
  logic        u_tx_busy = 1'b0;
  logic        u_rx_ready = 1'b0;
  logic [15:0] u_dout = '0;

  bus_bridge_slave_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .u_din(u_din), .u_en(u_en), .u_tx_busy(u_tx_busy),
    .u_rx_ready(u_rx_ready), .u_dout(u_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model state: window of the outstanding transaction and its expected result.
  int          exp_s = -10;
  int          exp_rsp = -10;
  logic [31:0] exp_din = '0;
  logic [7:0]  exp_rdata = '0;
  logic        exp_to = 1'b0;
  logic [7:0]  held_rdata = '0;
  logic        held_to = 1'b0;
  bit          chk_en = 1'b0;
  bit          started = 1'b0;
  bit          inflight;
  logic [31:0] last_din = '0;
  logic [7:0]  last_rdata = '0;
  logic        last_to = 1'b0;
  int          en_count = 0;
  int          rsp_count = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      inflight = (cyc >= exp_s) && (cyc <= exp_rsp);
      if (cyc == exp_rsp) begin
        held_rdata = exp_rdata;
        held_to    = exp_to;
      end
      chk("req_ready", 32'(req_ready), 32'(!inflight));
      chk("u_en", 32'(u_en), 32'(cyc == exp_s));
      if (u_en) begin
        last_din = u_din;
        en_count++;
      end
      if (cyc == exp_s) chk("u_din", u_din, exp_din);
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc == exp_rsp));
      if (rsp_valid) begin
        rsp_count++;
        last_rdata = rsp_rdata;
        last_to    = rsp_timeout;
      end
      chk("rsp_rdata", 32'(rsp_rdata), 32'(held_rdata));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(held_to));
    end else if (started) begin
      chk("rsp_valid_during_reset", 32'(rsp_valid), 32'd0);
    end
  end

  // r < 0: no reply; otherwise the reply rises r cycles after the read enters its wait.
  task automatic txn(input bit mode, input logic [13:0] addr, input logic [7:0] data,
                     input int d1, input int d2, input int r, input logic [15:0] word);
    int s;
    int n;
    req_valid = 1'b1;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = data;
    s = cyc + 1;
    n = s + d1 + d2 + 1;
    exp_din = (32'(mode) << 24) | (mode ? (32'(data) << 16) : 32'd0) | 32'(addr);
    if (mode) begin
      exp_rsp = n; exp_rdata = 8'h00; exp_to = 1'b0;
    end else if (r >= 0 && r <= T - 1) begin
      exp_rsp = n + r + 1; exp_rdata = word[7:0]; exp_to = 1'b0;
    end else begin
      exp_rsp = n + T; exp_rdata = 8'h00; exp_to = 1'b1;
    end
    exp_s = s;
    en_count = 0;
    rsp_count = 0;
    step();
    req_valid = 1'b0;
    req_mode  = 1'($urandom);
    req_addr  = 14'($urandom);
    req_wdata = 8'($urandom);
    repeat (d1) step();
    u_tx_busy = 1'b1;
    repeat (d2) step();
    u_tx_busy = 1'b0;
    if (!mode && r >= 0) begin
      step();
      repeat (r) step();
      u_rx_ready = 1'b1;
      u_dout = word;
      step();
      step();
      u_rx_ready = 1'b0;
    end
    while (cyc <= exp_rsp) step();
    chk("u_en_pulses", 32'(en_count), 32'd1);
    chk("rsp_pulses", 32'(rsp_count), 32'd1);
  endtask

  task automatic spurious(input logic [15:0] word);
    u_rx_ready = 1'b1;
    u_dout = word;
    step();
    u_rx_ready = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int sel;
    int r;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_u_en", 32'(u_en), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_u_din", u_din, 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    started = 1'b1;
    chk_en = 1'b1;
    step();

    txn(1'b1, 14'h0123, 8'hA5, 2, 5, -1, 16'h0);
    chk("dir_write_frame", last_din, 32'h01A50123);
    chk("dir_write_timeout", 32'(last_to), 32'd0);
    step();

    txn(1'b0, 14'h3FFF, 8'hEE, 1, 3, 3, 16'h003C);
    chk("dir_read_frame", last_din, 32'h00003FFF);
    chk("dir_read_rdata", 32'(last_rdata), 32'h3C);
    chk("dir_read_timeout", 32'(last_to), 32'd0);
    step();

    txn(1'b0, 14'h0042, 8'h00, 1, 1, -1, 16'h0);
    chk("dir_timeout_flag", 32'(last_to), 32'd1);
    chk("dir_timeout_rdata", 32'(last_rdata), 32'h00);
    step();

    spurious(16'h0055);
    txn(1'b0, 14'h1000, 8'h00, 2, 2, 0, 16'h1277);
    chk("dir_spurious_rdata", 32'(last_rdata), 32'h77);

    txn(1'b0, 14'h0001, 8'h00, 1, 2, T - 1, 16'h00C9);
    chk("dir_edge_beats_timeout_rdata", 32'(last_rdata), 32'hC9);
    chk("dir_edge_beats_timeout_flag", 32'(last_to), 32'd0);
    step();

    // Reset while a write sits in TX_DONE.
    req_valid = 1'b1; req_mode = 1'b1; req_addr = 14'h0ABC; req_wdata = 8'h5A;
    exp_din = 32'h015A0ABC;
    exp_s = cyc + 1;
    exp_rsp = exp_s + 100000;
    step();
    req_valid = 1'b0;
    u_tx_busy = 1'b1;
    repeat (3) step();
    chk_en = 1'b0;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    u_tx_busy = 1'b0;
    exp_s = -10;
    exp_rsp = -10;
    held_rdata = 8'h00;
    held_to = 1'b0;
    chk_en = 1'b1;
    repeat (5) step();
    chk("mid_reset_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       r = -1;
        1:       r = T - 1;
        2:       r = T + int'($urandom_range(0, 3));
        default: r = int'($urandom_range(0, T - 2));
      endcase
      if ($urandom_range(0, 2) == 0) spurious(16'($urandom));
      txn(1'($urandom), 14'($urandom), 8'($urandom),
          int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), r, 16'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
